// File: rtl/spi_frame_receiver_if.sv
// Pin and frame-output bundle for the SPI frame receiver.
// The slave side is the receiver; the master side drives the raw pins and consumes frames.
interface spi_frame_receiver_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              sclk;
  logic              ncs;
  logic              copi;
  logic              frame_valid;
  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  sclk, ncs, copi,
    output frame_valid, frame_rw, frame_addr, frame_data, frame_err, busy
  );

  modport master (
    output sclk, ncs, copi,
    input  frame_valid, frame_rw, frame_addr, frame_data, frame_err, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: synchronises raw pins into clk and emits {rw, addr, data}
// frames; transactions with the wrong bit count are flagged and never presented as valid.
module spi_frame_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_frame_receiver_if.slave   bus
);
  localparam int unsigned FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_q, ncs_q;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  state_t                 state, state_n;
  logic [FRAME_BITS-1:0]  shift_reg, shift_n;
  logic [CNT_W-1:0]       bit_cnt, cnt_n;
  logic                   overrun, ovr_n;
  logic                   valid_n, err_n, frame_ok;

  // Equal-depth synchronisers keep copi aligned with sclk; ncs idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ncs_sync  <= '1;
      copi_sync <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.copi};
      sclk_q    <= sclk_s;
      ncs_q     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = ~ncs_s & ncs_q;
  assign ncs_rise  = ncs_s & ~ncs_q;
  assign frame_ok  = (bit_cnt == CNT_W'(FRAME_BITS)) && !overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= cnt_n;
      overrun   <= ovr_n;
    end
  end

  // An sclk edge coinciding with either ncs edge is dropped: ncs has priority.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = bit_cnt;
    ovr_n   = overrun;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ncs_fall) begin
          shift_n = '0;
          cnt_n   = '0;
          ovr_n   = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          valid_n = frame_ok;
          err_n   = !frame_ok;
          state_n = IDLE;
        end else if (sclk_rise) begin
          shift_n = {shift_reg[FRAME_BITS-2:0], copi_s};
          cnt_n   = bit_cnt + CNT_W'(1);
          if (cnt_n == CNT_W'(FRAME_BITS)) state_n = FULL;
        end
      end
      FULL: begin
        if (ncs_rise) begin
          valid_n = frame_ok;
          err_n   = !frame_ok;
          state_n = IDLE;
        end else if (sclk_rise) begin
          ovr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame fields only ever load from a good frame and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.frame_rw    <= 1'b0;
      bus.frame_addr  <= '0;
      bus.frame_data  <= '0;
      bus.busy        <= 1'b0;
    end else begin
      bus.frame_valid <= valid_n;
      bus.frame_err   <= err_n;
      bus.busy        <= ~ncs_s;
      if (valid_n) begin
        bus.frame_rw   <= shift_reg[FRAME_BITS-1];
        bus.frame_addr <= shift_reg[DATA_W +: ADDR_W];
        bus.frame_data <= shift_reg[DATA_W-1:0];
      end
    end
  end
endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Front end of the SPI control path. It synchronises the raw SCLK/nCS/COPI pins into the system clock domain and shifts in 16-bit mode-0 frames, MSB first. It emits each complete frame as a one-cycle-qualified {rw, addr, data} word to the register bank that drives the PWM peripheral. Malformed frames (wrong bit count) are flagged and never presented as valid.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of each pin synchroniser; legal range ≥2.
- ADDR_W, 7: address field width.
- DATA_W, 8: data field width. Frame length is FRAME_BITS = 1 + ADDR_W + DATA_W (16 by default).

Ports:
- clk  input  1  system clock; the single clock for the block.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  raw SPI clock pin; asynchronous to clk.
- ncs  input  1  raw active-low chip select pin; asynchronous.
- copi  input  1  raw controller-out data pin; asynchronous.
- frame_valid  output  1  one-cycle pulse: frame_rw, frame_addr and frame_data hold a new good frame.
- frame_rw  output  1  bit FRAME_BITS-1 of the frame (1 = write).
- frame_addr  output  ADDR_W  next ADDR_W bits of the frame.
- frame_data  output  DATA_W  last DATA_W bits of the frame.
- frame_err  output  1  one-cycle pulse: transaction ended with bit count ≠ FRAME_BITS.
- busy  output  1  synchronised chip select is active (ncs_s low).

## Operation
- Each pin passes through a SYNC_STAGES-deep synchroniser.
- The ncs chain resets to 1. The sclk and copi chains reset to 0.
- One further register per pin holds the previous synchronised value. Edges are detected from that register and the synchroniser output:
  - sclk_rise = sclk_s & ~sclk_q
  - ncs_fall = ~ncs_s & ncs_q
  - ncs_rise = ncs_s & ~ncs_q
- COPI is sampled as copi_s in the cycle of sclk_rise. Because all three chains have equal depth, data and clock stay aligned.
- FSM states:
  - IDLE: waiting for ncs_fall. On ncs_fall, clear the shift register and bit count, then go to SHIFT.
  - SHIFT: on each sclk_rise, shift copi_s into bit 0 and increment the count. When the count reaches FRAME_BITS, go to FULL. On ncs_rise, go to IDLE.
  - FULL: further sclk_rise sets the overrun flag; the shift register is frozen. On ncs_rise, go to IDLE.
- Frame end, evaluated on ncs_rise:
  - Count == FRAME_BITS with no overrun: pulse frame_valid and load the outputs from the shift register.
  - Any other count, including 0, or overrun set: pulse frame_err; frame outputs are unchanged.
- Frame outputs hold the last good frame indefinitely. They are never altered by bad frames.
- Simultaneous events:
  - sclk_rise in the same cycle as ncs_rise: the sclk edge is discarded.
  - sclk_rise in the same cycle as ncs_fall: the sclk edge is discarded.
- Reset mid-frame: all state and outputs clear immediately. If ncs is still low at release, the chain sees a falling edge, enters SHIFT and counts only the remaining bits. The resulting short frame ends in frame_err.

## Timing
- Reset values:
  - frame_valid, frame_err, frame_rw: 0
  - frame_addr, frame_data: 0
  - busy: 0
  - FSM: IDLE
- Pin-to-event latency: SYNC_STAGES+1 clk edges from the first edge that samples the new pin level. With the default of 2, that is 3 edges.
- frame_valid and frame_err are registered. They are high for exactly one clk cycle, in the cycle after the ncs_rise detection edge.
- Data fields change on that same edge and remain stable afterwards.
- frame_valid and frame_err are never high together.
- busy follows ncs_s with one register of delay.
- Input constraint: SCLK high and low phases are each ≥ SYNC_STAGES clk periods (clk ≥ 4× SCLK at default).
- Input constraint: nCS setup and hold to first and last SCLK edges ≥ 2 clk periods.
- Violating the input constraints is unsupported, but must never produce frame_valid with a wrong bit count.
- No backpressure: the consumer must accept frame_valid in the cycle it is asserted.

## Test plan
- Reset check: hold rst high with random pin activity -> all outputs 0. Release with ncs high and send write 0x80, addr 0x00, data 0xF0 (bits 1000_0000_1111_0000) -> one frame_valid pulse; rw=1, addr=0x00, data=0xF0; frame_err stays 0.
- Back-to-back frames: send 0x8155 then 0x04AA with minimum nCS high gap -> two frame_valid pulses; first rw=1/addr=0x01/data=0x55, second rw=0/addr=0x04/data=0xAA; no frame_err.
- Short frame: send 15 SCLK rises -> frame_err pulse and no frame_valid; outputs keep the previous frame's values.
- Zero-bit frame: toggle nCS with no SCLK edges -> frame_err pulse.
- Long frame: 17 SCLK rises -> frame_err pulse and no frame_valid; outputs keep the previous frame's values.
- Reset mid-frame: assert rst after 8 bits, release with ncs low, finish the 8 remaining bits -> frame_err pulse and no frame_valid; next full frame 0x83C3 -> frame_valid with addr=0x03, data=0xC3.
- Edge collision: align the 16th SCLK rise with the nCS rise in the same synchronised cycle -> frame_err (count 15), no frame_valid.
- Timing limit: drive SCLK at clk/4 -> each frame_valid lands exactly 3 clk edges after the sampled nCS rise, with correct data throughout.
